npc_multicycle_ctrl: RTL and testbench
======================================

Name: npc_multicycle_ctrl

Overview:
Multi-cycle sequencer that replaces the single-cycle top's free-running fetch. It fetches each instruction and performs each data access over valid/ready memory ports, so the core tolerates memories with wait states. It holds the instruction register, owns the PC, and gates register/CSR write-back. The existing IF/ID/EX/MEM datapath logic is reused combinationally between its stage enables.

Parameters:
XLEN, 64, register/data width (RegBus)
ILEN, 32, instruction width (InstBus)
RESET_PC, 64'h8000_0000, PC value loaded on reset
INST_ALIGN, 2, number of low PC bits that must be zero (2 = 4-byte alignment)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active-low
if_valid  out  1  instruction fetch request
if_addr  out  XLEN  fetch address (= pc_o)
if_ready  in  1  fetch accepted; if_rdata valid in the same cycle
if_rdata  in  ILEN  fetched instruction
dm_valid  out  1  data access request
dm_we  out  1  1 = store
dm_addr  out  XLEN  byte address
dm_wdata  out  XLEN  store data, lane-aligned
dm_wstrb  out  XLEN/8  byte strobes
dm_ready  in  1  access done; dm_rdata valid in the same cycle
dm_rdata  in  XLEN  load data, full doubleword
ex_mem_ce  in  1  current instruction accesses memory
ex_mem_we  in  1  current instruction is a store
ex_mem_addr  in  XLEN  effective address
ex_mem_wdata  in  XLEN  store value, unaligned
ex_mem_size  in  2  access size: 0 = B, 1 = H, 2 = W, 3 = D
ex_mem_unsigned  in  1  zero-extend load
ex_jump_flag  in  1  take jump
ex_jump_addr  in  XLEN  jump target
ex_halt  in  1  ebreak decoded
pc_o  out  XLEN  current PC
inst_o  out  ILEN  instruction register
load_data_o  out  XLEN  extended load result, registered
wb_en  out  1  GPR write strobe (AND with wreg)
csr_wb_en  out  1  CSR write strobe
halted  out  1  core stopped
halt_err  out  1  stop was caused by a misaligned jump

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n).
- Reset values:
  - state = FETCH, pc_o = RESET_PC.
  - inst_o = 0 (NOP encoding 32'h13 is not used; 0 is decided).
  - load_data_o = 0.
  - halted = 0, halt_err = 0.
  - All request and strobe outputs are 0 while rst_n is low. An in-flight request is dropped.
- FETCH:
  - if_valid = 1.
  - When if_ready = 1: inst_o <= if_rdata, go to EXEC.
  - if_addr is stable while waiting.
- EXEC:
  - One cycle; the datapath evaluates inst_o.
  - If ex_mem_ce = 1, go to MEM; otherwise go to WB.
- MEM:
  - dm_valid = 1 and dm_we = ex_mem_we. ex_* inputs are required to stay stable (IR and regfile are frozen).
  - dm_wstrb = size mask shifted by addr[2:0]; dm_wdata = ex_mem_wdata shifted by 8*addr[2:0].
  - On dm_ready = 1 for a load: extract the lane at addr[2:0], sign-extend or zero-extend per ex_mem_unsigned, register into load_data_o. Then go to WB.
  - Misaligned data access (address not a multiple of the size) is not detected; behaviour is undefined.
- WB:
  - wb_en = 1 and csr_wb_en = 1 for exactly one cycle.
  - pc_o <= ex_jump_flag ? ex_jump_addr : pc_o + 4, computed with XLEN-bit wrap.
  - If ex_halt = 1: go to HALT; the PC is not advanced.
  - Else if ex_jump_flag = 1 and ex_jump_addr[INST_ALIGN-1:0] != 0: go to HALT with halt_err = 1; pc_o is left unchanged.
  - Otherwise go to FETCH.
- HALT: absorbing state; halted = 1 and all request and strobe outputs are 0. Only reset leaves it.
- Latency: a non-memory instruction takes 3 cycles plus fetch wait cycles. A memory instruction takes 4 cycles plus fetch and data wait cycles.
- The ready inputs are ignored outside their respective states.

Optional Feature:
NPC_PERF_CNT_EN
- Defined:
  - Adds outputs perf_cycle (64 bit) and perf_instret (64 bit), both reset to 0.
  - perf_cycle increments every cycle while not halted.
  - perf_instret increments in every WB cycle, including the WB cycle that halts.
  - perf_if_stall (32 bit) counts FETCH cycles with if_ready = 0, saturating.
- Undefined: these ports and counters do not exist.

Decomposition:
- Shared package defines.v gets:
  - the state encoding (`NPC_S_FETCH/EXEC/MEM/WB/HALT`);
  - the size codes `MEM_SIZE_B/H/W/D`;
  - the `RESET_PC` default.
- One sub-module, npc_lsu_align: purely combinational. It produces the store lane shift, the strobe mask, and the load extract/extend. It is reused by a later pipelined MEM stage.

Test Plan:
- Reset and fetch: rst_n low for 2 cycles, then high, with if_ready tied to 1 → if_addr = 0x8000_0000 in the first FETCH cycle; wb_en pulses every 3rd cycle; pc_o goes 0x8000_0000 → 0x8000_0004 → 0x8000_0008.
- Fetch wait states: if_ready held at 0 for 5 cycles → if_valid and if_addr stay stable; inst_o is captured only when if_ready = 1; no wb_en pulse during the stall.
- Load byte, signed:
  - Stimulus: ex_mem_ce = 1, ex_mem_we = 0, size = B, addr = 0x8000_0103, dm_rdata = 0x0000_0000_8000_0000 (byte at lane 3 = 0x80), dm_ready delayed 2 cycles.
  - Response: load_data_o = 0xFFFF_FFFF_FFFF_FF80.
  - Same access with ex_mem_unsigned = 1 → load_data_o = 0x80.
- Store halfword: addr = 0x...06, wdata = 0xBEEF → dm_wstrb = 8'b1100_0000, dm_wdata[63:48] = 0xBEEF.
- Jump handling: ex_jump_flag = 1 with addr 0x8000_0102 → halted = 1 and halt_err = 1, pc_o unchanged. With addr 0x8000_0100 → the next if_addr = 0x8000_0100.
- Halt and mid-operation reset:
  - ex_halt = 1 → halted = 1 with no further if_valid.
  - rst_n pulsed low during MEM with dm_valid high → the next cycle has dm_valid = 0, state = FETCH, pc_o = RESET_PC.

Source files
------------

// File: rtl/npc_multicycle_ctrl_pkg.sv
// npc_multicycle_ctrl_pkg
//   Shared constants for the multi-cycle sequencer and its load/store aligner:
//   FSM state encoding, memory access size codes, default reset PC, and a
//   helper that turns a size code into a byte-strobe mask.
package npc_multicycle_ctrl_pkg;

  // FSM encoding, kept as plain constants so older tools can read state dumps
  localparam logic [2:0] NPC_S_FETCH = 3'd0;
  localparam logic [2:0] NPC_S_EXEC  = 3'd1;
  localparam logic [2:0] NPC_S_MEM   = 3'd2;
  localparam logic [2:0] NPC_S_WB    = 3'd3;
  localparam logic [2:0] NPC_S_HALT  = 3'd4;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;
  localparam logic [1:0] MEM_SIZE_D = 2'd3;

  localparam logic [63:0] NPC_RESET_PC = 64'h8000_0000;

  // Unshifted strobe mask for a doubleword lane group
  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      MEM_SIZE_B: size_mask = 8'h01;
      MEM_SIZE_H: size_mask = 8'h03;
      MEM_SIZE_W: size_mask = 8'h0F;
      default:    size_mask = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/npc_multicycle_ctrl_lsu_align.sv
// npc_lsu_align
//   Purely combinational load/store lane aligner.
//   off     : byte offset within the doubleword (addr[2:0])
//   size    : access size code (B/H/W/D)
//   uns     : zero-extend loads when 1
//   st_data : store value, right-justified
//   st_lane : store value moved to its byte lanes
//   st_strb : byte strobes for the access
//   ld_raw  : full doubleword read from memory
//   ld_ext  : selected lane, sign/zero-extended to XLEN
module npc_lsu_align
  import npc_multicycle_ctrl_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int OFF_W = $clog2(XLEN/8)
) (
  input  logic [OFF_W-1:0]  off,
  input  logic [1:0]        size,
  input  logic              uns,
  input  logic [XLEN-1:0]   st_data,
  output logic [XLEN-1:0]   st_lane,
  output logic [XLEN/8-1:0] st_strb,
  input  logic [XLEN-1:0]   ld_raw,
  output logic [XLEN-1:0]   ld_ext
);
  localparam int SW = XLEN/8;

  logic [XLEN-1:0] ld_sh;

  assign st_lane = st_data << {off, 3'b000};
  assign st_strb = SW'(size_mask(size)) << off;
  assign ld_sh   = ld_raw >> {off, 3'b000};

  always_comb begin
    ld_ext = ld_sh;
    case (size)
      MEM_SIZE_B: ld_ext = {{(XLEN-8){~uns & ld_sh[7]}},   ld_sh[7:0]};
      MEM_SIZE_H: ld_ext = {{(XLEN-16){~uns & ld_sh[15]}}, ld_sh[15:0]};
      MEM_SIZE_W: ld_ext = {{(XLEN-32){~uns & ld_sh[31]}}, ld_sh[31:0]};
      default:    ld_ext = ld_sh;
    endcase
  end

endmodule

// File: rtl/npc_multicycle_ctrl.sv
// npc_multicycle_ctrl
//   Multi-cycle sequencer: FETCH -> EXEC -> [MEM] -> WB -> FETCH, with an
//   absorbing HALT. Fetches and data accesses use valid/ready handshakes so
//   memories may insert wait states. Owns the PC and the instruction register,
//   registers aligned/extended load data, and strobes GPR/CSR write-back.
//   Ports:
//     clk, rst_n                    clock, synchronous active-low reset
//     if_valid/if_addr/if_ready/if_rdata   instruction fetch port
//     dm_valid/dm_we/dm_addr/dm_wdata/dm_wstrb/dm_ready/dm_rdata  data port
//     ex_*                          combinational datapath results for inst_o
//     pc_o, inst_o, load_data_o     architectural state to the datapath
//     wb_en, csr_wb_en              one-cycle write-back strobes
//     halted, halt_err              stop status (halt_err = misaligned jump)
//   Optional macro NPC_PERF_CNT_EN adds perf_cycle, perf_instret and
//   perf_if_stall counters.
module npc_multicycle_ctrl
  import npc_multicycle_ctrl_pkg::*;
#(
  parameter int          XLEN       = 64,
  parameter int          ILEN       = 32,
  parameter logic [63:0] RESET_PC   = NPC_RESET_PC,
  parameter int          INST_ALIGN = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              if_valid,
  output logic [XLEN-1:0]   if_addr,
  input  logic              if_ready,
  input  logic [ILEN-1:0]   if_rdata,
  output logic              dm_valid,
  output logic              dm_we,
  output logic [XLEN-1:0]   dm_addr,
  output logic [XLEN-1:0]   dm_wdata,
  output logic [XLEN/8-1:0] dm_wstrb,
  input  logic              dm_ready,
  input  logic [XLEN-1:0]   dm_rdata,
  input  logic              ex_mem_ce,
  input  logic              ex_mem_we,
  input  logic [XLEN-1:0]   ex_mem_addr,
  input  logic [XLEN-1:0]   ex_mem_wdata,
  input  logic [1:0]        ex_mem_size,
  input  logic              ex_mem_unsigned,
  input  logic              ex_jump_flag,
  input  logic [XLEN-1:0]   ex_jump_addr,
  input  logic              ex_halt,
  output logic [XLEN-1:0]   pc_o,
  output logic [ILEN-1:0]   inst_o,
  output logic [XLEN-1:0]   load_data_o,
  output logic              wb_en,
  output logic              csr_wb_en,
`ifdef NPC_PERF_CNT_EN
  output logic [63:0]       perf_cycle,
  output logic [63:0]       perf_instret,
  output logic [31:0]       perf_if_stall,
`endif
  output logic              halted,
  output logic              halt_err
);
  localparam int OFF_W = $clog2(XLEN/8);

  logic [2:0]        state;
  logic [XLEN-1:0]   st_lane;
  logic [XLEN/8-1:0] st_strb;
  logic [XLEN-1:0]   ld_ext;
  logic [XLEN-1:0]   pc_next;
  logic              jump_misal;

  npc_lsu_align #(.XLEN(XLEN), .OFF_W(OFF_W)) u_lsu_align (
    .off     (ex_mem_addr[OFF_W-1:0]),
    .size    (ex_mem_size),
    .uns     (ex_mem_unsigned),
    .st_data (ex_mem_wdata),
    .st_lane (st_lane),
    .st_strb (st_strb),
    .ld_raw  (dm_rdata),
    .ld_ext  (ld_ext)
  );

  // Outputs are gated with rst_n so a request in flight vanishes the moment
  // reset is asserted, not one cycle later when the state register clears.
  assign if_valid  = rst_n & (state == NPC_S_FETCH);
  assign if_addr   = pc_o;
  assign dm_valid  = rst_n & (state == NPC_S_MEM);
  assign dm_we     = dm_valid & ex_mem_we;
  assign dm_addr   = ex_mem_addr;
  assign dm_wdata  = st_lane;
  assign dm_wstrb  = dm_valid ? st_strb : '0;
  assign wb_en     = rst_n & (state == NPC_S_WB);
  assign csr_wb_en = wb_en;
  assign halted    = rst_n & (state == NPC_S_HALT);

  assign pc_next    = ex_jump_flag ? ex_jump_addr : pc_o + XLEN'(4);
  assign jump_misal = ex_jump_flag & (|ex_jump_addr[INST_ALIGN-1:0]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= NPC_S_FETCH;
      pc_o        <= RESET_PC[XLEN-1:0];
      inst_o      <= '0;
      load_data_o <= '0;
      halt_err    <= 1'b0;
    end else begin
      case (state)
        NPC_S_FETCH: if (if_ready) begin
          inst_o <= if_rdata;
          state  <= NPC_S_EXEC;
        end
        NPC_S_EXEC: state <= ex_mem_ce ? NPC_S_MEM : NPC_S_WB;
        NPC_S_MEM: if (dm_ready) begin
          if (!ex_mem_we) load_data_o <= ld_ext;
          state <= NPC_S_WB;
        end
        NPC_S_WB: begin
          // halt and bad-target jump both freeze the PC at the culprit
          if (ex_halt) begin
            state <= NPC_S_HALT;
          end else if (jump_misal) begin
            state    <= NPC_S_HALT;
            halt_err <= 1'b1;
          end else begin
            pc_o  <= pc_next;
            state <= NPC_S_FETCH;
          end
        end
        NPC_S_HALT: ;
        default: state <= NPC_S_FETCH;
      endcase
    end
  end

`ifdef NPC_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_cycle    <= '0;
      perf_instret  <= '0;
      perf_if_stall <= '0;
    end else begin
      if (state != NPC_S_HALT) perf_cycle <= perf_cycle + 64'd1;
      if (state == NPC_S_WB)   perf_instret <= perf_instret + 64'd1;
      if (state == NPC_S_FETCH && !if_ready && perf_if_stall != '1)
        perf_if_stall <= perf_if_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_npc_multicycle_ctrl.sv
module tb_npc_multicycle_ctrl;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_valid;
  logic [63:0] if_addr;
  logic        if_ready = 1'b1;
  logic [31:0] if_rdata = '0;
  logic        dm_valid, dm_we;
  logic [63:0] dm_addr, dm_wdata;
  logic [7:0]  dm_wstrb;
  logic        dm_ready = 1'b0;
  logic [63:0] dm_rdata = '0;
  logic        ex_mem_ce = 1'b0, ex_mem_we = 1'b0, ex_mem_unsigned = 1'b0;
  logic [63:0] ex_mem_addr = '0, ex_mem_wdata = '0, ex_jump_addr = '0;
  logic [1:0]  ex_mem_size = '0;
  logic        ex_jump_flag = 1'b0, ex_halt = 1'b0;
  logic [63:0] pc_o, load_data_o;
  logic [31:0] inst_o;
  logic        wb_en, csr_wb_en, halted, halt_err;
`ifdef NPC_PERF_CNT_EN
  logic [63:0] perf_cycle, perf_instret;
  logic [31:0] perf_if_stall;
`endif

  int n_pass = 0;
  int n_chk  = 0;
  logic [63:0] exp_pc;

  always #5 clk = ~clk;

  npc_multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .dm_valid(dm_valid), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
    .ex_mem_ce(ex_mem_ce), .ex_mem_we(ex_mem_we), .ex_mem_addr(ex_mem_addr),
    .ex_mem_wdata(ex_mem_wdata), .ex_mem_size(ex_mem_size),
    .ex_mem_unsigned(ex_mem_unsigned), .ex_jump_flag(ex_jump_flag),
    .ex_jump_addr(ex_jump_addr), .ex_halt(ex_halt),
    .pc_o(pc_o), .inst_o(inst_o), .load_data_o(load_data_o),
    .wb_en(wb_en), .csr_wb_en(csr_wb_en),
`ifdef NPC_PERF_CNT_EN
    .perf_cycle(perf_cycle), .perf_instret(perf_instret), .perf_if_stall(perf_if_stall),
`endif
    .halted(halted), .halt_err(halt_err)
  );

  task automatic step;
    @(posedge clk); #1;
  endtask

  // FETCH -> EXEC -> WB -> FETCH for a non-memory instruction
  task automatic run_plain;
    if_ready = 1'b1; step; step; step;
  endtask

  // Runs one memory instruction from FETCH back to FETCH; returns what was seen
  task automatic run_mem(input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata, input int waits,
                         output logic o_vld, output logic o_we, output logic [7:0] o_strb,
                         output logic [63:0] o_wdata, output logic [63:0] o_ld,
                         output logic o_wb);
    if_ready = 1'b1; step;
    ex_mem_ce = 1'b1; ex_mem_we = we; ex_mem_size = size; ex_mem_unsigned = uns;
    ex_mem_addr = addr; ex_mem_wdata = wdata; dm_rdata = rdata; dm_ready = 1'b0;
    step;
    o_vld = dm_valid; o_we = dm_we; o_strb = dm_wstrb; o_wdata = dm_wdata;
    for (int i = 0; i < waits; i++) begin
      step;
      if (!dm_valid || wb_en) o_vld = 1'b0;
    end
    dm_ready = 1'b1; step;
    o_ld = load_data_o; o_wb = wb_en;
    ex_mem_ce = 1'b0; ex_mem_we = 1'b0; dm_ready = 1'b0;
    step;
    exp_pc = exp_pc + 64'd4;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; if_ready = 1'b1; step; step;
    n_chk++; if (if_valid !== 1'b0) $display("FAIL rst_if_valid got %b want 0", if_valid); else n_pass++;
    n_chk++; if (pc_o !== RST_PC) $display("FAIL rst_pc got %h want %h", pc_o, RST_PC); else n_pass++;
    n_chk++; if (inst_o !== 32'h0) $display("FAIL rst_inst got %h want 0", inst_o); else n_pass++;
    n_chk++; if (load_data_o !== 64'h0) $display("FAIL rst_load got %h want 0", load_data_o); else n_pass++;
    n_chk++; if ({wb_en, csr_wb_en, halted, halt_err, dm_valid} !== 5'b0)
      $display("FAIL rst_flags got %b want 00000", {wb_en, csr_wb_en, halted, halt_err, dm_valid}); else n_pass++;
    rst_n = 1'b1; #1;
    n_chk++; if (if_valid !== 1'b1 || if_addr !== RST_PC)
      $display("FAIL first_fetch got v=%b a=%h want v=1 a=%h", if_valid, if_addr, RST_PC); else n_pass++;
    exp_pc = RST_PC;
  endtask

  task automatic test_fetch;
    if_rdata = 32'h0000_0093; step;
    n_chk++; if (inst_o !== 32'h93 || wb_en !== 1'b0) $display("FAIL exec_ir got %h wb=%b want 93 wb=0", inst_o, wb_en); else n_pass++;
    step;
    n_chk++; if (wb_en !== 1'b1 || csr_wb_en !== 1'b1 || pc_o !== RST_PC)
      $display("FAIL wb_pulse got wb=%b csr=%b pc=%h want 1 1 %h", wb_en, csr_wb_en, pc_o, RST_PC); else n_pass++;
    step;
    n_chk++; if (wb_en !== 1'b0 || pc_o !== 64'h8000_0004 || if_addr !== 64'h8000_0004)
      $display("FAIL pc_inc1 got wb=%b pc=%h want 0 80000004", wb_en, pc_o); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step;
      n_chk++; if (wb_en !== (i == 1)) $display("FAIL wb_cadence cyc%0d got %b want %b", i, wb_en, (i == 1)); else n_pass++;
    end
    n_chk++; if (pc_o !== 64'h8000_0008) $display("FAIL pc_inc2 got %h want 80000008", pc_o); else n_pass++;
    exp_pc = 64'h8000_0008;
  endtask

  task automatic test_fetch_wait;
    if_ready = 1'b0; if_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      step;
      n_chk++; if (if_valid !== 1'b1 || if_addr !== exp_pc || inst_o !== 32'h93 || wb_en !== 1'b0)
        $display("FAIL fetch_stall cyc%0d got v=%b a=%h ir=%h wb=%b want 1 %h 93 0", i, if_valid, if_addr, inst_o, wb_en, exp_pc);
      else n_pass++;
    end
    if_ready = 1'b1; if_rdata = 32'h0010_0113; step;
    n_chk++; if (inst_o !== 32'h0010_0113) $display("FAIL fetch_capture got %h want 00100113", inst_o); else n_pass++;
    step; step;
    exp_pc = exp_pc + 64'd4;
    n_chk++; if (pc_o !== exp_pc) $display("FAIL pc_after_stall got %h want %h", pc_o, exp_pc); else n_pass++;
  endtask

  task automatic test_load;
    logic v, w, wb; logic [7:0] s; logic [63:0] d, ld;
    run_mem(1'b0, 2'd0, 1'b0, 64'h8000_0103, 64'h0, 64'h0000_0000_8000_0000, 2, v, w, s, d, ld, wb);
    n_chk++; if (v !== 1'b1 || w !== 1'b0) $display("FAIL lb_req got v=%b we=%b want 1 0", v, w); else n_pass++;
    n_chk++; if (ld !== 64'hFFFF_FFFF_FFFF_FF80) $display("FAIL lb_signed got %h want ffffffffffffff80", ld); else n_pass++;
    n_chk++; if (wb !== 1'b1) $display("FAIL lb_wb got %b want 1", wb); else n_pass++;
    run_mem(1'b0, 2'd0, 1'b1, 64'h8000_0103, 64'h0, 64'h0000_0000_8000_0000, 0, v, w, s, d, ld, wb);
    n_chk++; if (ld !== 64'h80) $display("FAIL lbu got %h want 80", ld); else n_pass++;
    run_mem(1'b0, 2'd1, 1'b0, 64'h8000_0202, 64'h0, 64'h0000_0000_ABCD_0000, 1, v, w, s, d, ld, wb);
    n_chk++; if (ld !== 64'hFFFF_FFFF_FFFF_ABCD) $display("FAIL lh got %h want ffffffffffffabcd", ld); else n_pass++;
    run_mem(1'b0, 2'd2, 1'b1, 64'h8000_0304, 64'h0, 64'h8765_4321_0000_0000, 0, v, w, s, d, ld, wb);
    n_chk++; if (ld !== 64'h0000_0000_8765_4321) $display("FAIL lwu got %h want 0000000087654321", ld); else n_pass++;
    run_mem(1'b0, 2'd2, 1'b0, 64'h8000_0304, 64'h0, 64'h8765_4321_0000_0000, 0, v, w, s, d, ld, wb);
    n_chk++; if (ld !== 64'hFFFF_FFFF_8765_4321) $display("FAIL lw got %h want ffffffff87654321", ld); else n_pass++;
    run_mem(1'b0, 2'd3, 1'b0, 64'h8000_0400, 64'h0, 64'h0123_4567_89AB_CDEF, 0, v, w, s, d, ld, wb);
    n_chk++; if (ld !== 64'h0123_4567_89AB_CDEF) $display("FAIL ld got %h want 0123456789abcdef", ld); else n_pass++;
    n_chk++; if (pc_o !== exp_pc) $display("FAIL pc_after_loads got %h want %h", pc_o, exp_pc); else n_pass++;
  endtask

  task automatic test_store;
    logic v, w, wb; logic [7:0] s; logic [63:0] d, ld;
    run_mem(1'b1, 2'd1, 1'b0, 64'h8000_0206, 64'h0000_0000_0000_BEEF, 64'hFFFF_FFFF_FFFF_FFFF, 1, v, w, s, d, ld, wb);
    n_chk++; if (v !== 1'b1 || w !== 1'b1) $display("FAIL sh_req got v=%b we=%b want 1 1", v, w); else n_pass++;
    n_chk++; if (s !== 8'b1100_0000) $display("FAIL sh_strb got %b want 11000000", s); else n_pass++;
    n_chk++; if (d !== 64'hBEEF_0000_0000_0000) $display("FAIL sh_wdata got %h want beef000000000000", d); else n_pass++;
    n_chk++; if (ld !== 64'h0123_4567_89AB_CDEF) $display("FAIL store_keeps_load got %h want 0123456789abcdef", ld); else n_pass++;
    run_mem(1'b1, 2'd2, 1'b0, 64'h8000_0304, 64'h0000_0000_1234_5678, 64'h0, 0, v, w, s, d, ld, wb);
    n_chk++; if (s !== 8'hF0 || d !== 64'h1234_5678_0000_0000) $display("FAIL sw got strb=%h d=%h want f0 1234567800000000", s, d); else n_pass++;
    run_mem(1'b1, 2'd0, 1'b0, 64'h8000_0401, 64'h0000_0000_0000_00A5, 64'h0, 0, v, w, s, d, ld, wb);
    n_chk++; if (s !== 8'h02 || d !== 64'h0000_0000_0000_A500) $display("FAIL sb got strb=%h d=%h want 02 000000000000a500", s, d); else n_pass++;
    n_chk++; if (pc_o !== exp_pc) $display("FAIL pc_after_stores got %h want %h", pc_o, exp_pc); else n_pass++;
  endtask

  task automatic test_jump;
    if_ready = 1'b1; step;
    ex_jump_flag = 1'b1; ex_jump_addr = 64'h8000_0100; step;
    n_chk++; if (wb_en !== 1'b1) $display("FAIL jump_wb got %b want 1", wb_en); else n_pass++;
    step; ex_jump_flag = 1'b0;
    n_chk++; if (if_valid !== 1'b1 || if_addr !== 64'h8000_0100 || halted !== 1'b0)
      $display("FAIL jump_target got v=%b a=%h h=%b want 1 80000100 0", if_valid, if_addr, halted); else n_pass++;
    step;
    ex_jump_flag = 1'b1; ex_jump_addr = 64'h8000_0102; step; step; ex_jump_flag = 1'b0;
    n_chk++; if (halted !== 1'b1 || halt_err !== 1'b1) $display("FAIL misal_halt got h=%b e=%b want 1 1", halted, halt_err); else n_pass++;
    n_chk++; if (pc_o !== 64'h8000_0100) $display("FAIL misal_pc got %h want 80000100", pc_o); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step;
      n_chk++; if (if_valid !== 1'b0 || wb_en !== 1'b0 || halted !== 1'b1)
        $display("FAIL halt_absorb cyc%0d got v=%b wb=%b h=%b want 0 0 1", i, if_valid, wb_en, halted); else n_pass++;
    end
    rst_n = 1'b0; step; rst_n = 1'b1; #1;
    n_chk++; if (halted !== 1'b0 || halt_err !== 1'b0 || pc_o !== RST_PC)
      $display("FAIL halt_reset got h=%b e=%b pc=%h want 0 0 %h", halted, halt_err, pc_o, RST_PC); else n_pass++;
  endtask

  task automatic test_halt;
    if_ready = 1'b1; step;
    ex_halt = 1'b1; step;
    n_chk++; if (wb_en !== 1'b1) $display("FAIL ebreak_wb got %b want 1", wb_en); else n_pass++;
    step; ex_halt = 1'b0;
    n_chk++; if (halted !== 1'b1 || halt_err !== 1'b0 || pc_o !== RST_PC)
      $display("FAIL ebreak_halt got h=%b e=%b pc=%h want 1 0 %h", halted, halt_err, pc_o, RST_PC); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      step;
      n_chk++; if (if_valid !== 1'b0 || dm_valid !== 1'b0) $display("FAIL ebreak_quiet cyc%0d got if=%b dm=%b want 0 0", i, if_valid, dm_valid); else n_pass++;
    end
    rst_n = 1'b0; step; rst_n = 1'b1; #1;
  endtask

  task automatic test_mid_reset;
    run_plain;
    n_chk++; if (pc_o !== RST_PC + 64'd4) $display("FAIL mid_pre_pc got %h want %h", pc_o, RST_PC + 64'd4); else n_pass++;
    step;
    ex_mem_ce = 1'b1; ex_mem_we = 1'b1; ex_mem_size = 2'd3; ex_mem_addr = 64'h8000_0500; dm_ready = 1'b0;
    step;
    n_chk++; if (dm_valid !== 1'b1 || dm_wstrb !== 8'hFF) $display("FAIL mid_mem got v=%b s=%h want 1 ff", dm_valid, dm_wstrb); else n_pass++;
    rst_n = 1'b0; #1;
    n_chk++; if (dm_valid !== 1'b0 || dm_wstrb !== 8'h00) $display("FAIL mid_rst_low got v=%b s=%h want 0 00", dm_valid, dm_wstrb); else n_pass++;
    step; rst_n = 1'b1; ex_mem_ce = 1'b0; ex_mem_we = 1'b0; #1;
    n_chk++; if (dm_valid !== 1'b0 || if_valid !== 1'b1 || pc_o !== RST_PC)
      $display("FAIL mid_rst_after got dm=%b if=%b pc=%h want 0 1 %h", dm_valid, if_valid, pc_o, RST_PC); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_fetch_wait;
    test_load;
    test_store;
    test_jump;
    test_halt;
    test_mid_reset;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
